// File: rtl/axis_upsizer_pkg.sv
// Shared constants and helpers for the AXI-Stream byte-to-word upsizer.
package axis_upsizer_pkg;

    localparam int BYTE_W    = 8;
    localparam int MIN_RATIO = 2;
    localparam int MAX_RATIO = 8;

    // True when a bytes-per-word ratio is one the upsizer supports.
    function automatic bit ratio_ok(input int ratio);
        return (ratio >= MIN_RATIO) && (ratio <= MAX_RATIO);
    endfunction

    // Mask with the low n bits set; callers truncate it to their lane count.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int n);
        logic [MAX_RATIO-1:0] m;
        for (int i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// AXI-Stream bundle; BYTES sets the data width in bytes (1 on the input side).
interface axis_upsizer_if #(
    parameter int BYTES = 1
);
    import axis_upsizer_pkg::*;

    logic                      tvalid;
    logic                      tready;
    logic                      tlast;
    logic [BYTES*BYTE_W-1:0]   tdata;
    logic [BYTES-1:0]          tkeep;

    modport master (output tvalid, tlast, tdata, tkeep, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, output tready);

endinterface

// File: rtl/axis_upsizer.sv
// Packs an 8-bit AXI-Stream into RATIO-byte words, little-endian, emitting a
// word when it fills or on tlast. tkeep marks the filled lanes of a short
// final word. Backpressure stalls the whole path (no skid buffer).
module axis_upsizer
    import axis_upsizer_pkg::*;
#(
    parameter int RATIO = 4,
    parameter int CNT_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    axis_upsizer_if.slave     s_axis,
    axis_upsizer_if.master    m_axis,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int               WORD_W      = RATIO * BYTE_W;
    localparam int               IDX_W       = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(RATIO - 1);
    localparam bit               RATIO_LEGAL = ratio_ok(RATIO);

    if (!RATIO_LEGAL) begin : g_bad_ratio
        $error("axis_upsizer: RATIO must be within 2..8");
    end

    logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]  acc_keep_q, acc_keep_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]  out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

    logic              s_ready;
    logic              s_fire;
    logic              m_fire;
    logic              completing;
    logic [WORD_W-1:0] merged_data;
    logic [RATIO-1:0]  merged_keep;

    // Input is blocked only while a word is held that downstream is not taking.
    assign s_ready    = !areset && (!out_valid_q || m_axis.tready);
    assign s_fire     = s_axis.tvalid && s_ready;
    assign m_fire     = out_valid_q && m_axis.tready;
    assign completing = s_fire && ((byte_cnt_q == LAST_IDX) || s_axis.tlast);

    // Accumulator contents with the incoming byte dropped into lane byte_cnt.
    always_comb begin
        merged_data = acc_data_q | (WORD_W'(s_axis.tdata) << {byte_cnt_q, 3'b000});
        merged_keep = acc_keep_q | RATIO'(keep_mask(int'(byte_cnt_q) + 1));
    end

    // Accumulator next state: clear on a completing byte, else collect the byte.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        if (completing) begin
            byte_cnt_d = '0;
            acc_data_d = '0;
            acc_keep_d = '0;
        end else if (s_fire) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            acc_data_d = merged_data;
            acc_keep_d = merged_keep;
        end
    end

    // Output register next state: a new word wins over draining the old one.
    always_comb begin
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (completing) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = s_axis.tlast;
            out_valid_d = 1'b1;
        end else if (m_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Packet counter next state: one count per tlast word accepted downstream.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (m_fire && out_last_q) begin
            pkt_count_d = pkt_count_q + 1'b1;
        end
    end

    // Accumulator state; a reset drops any partial word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            byte_cnt_q <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
        end
    end

    // Output register; a reset drops any held word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Free-running packet counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = out_keep_q;
    assign m_axis.tlast  = out_last_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed and randomised checks of axis_upsizer at RATIO = 4.
module tb_axis_upsizer;

    localparam int RATIO = 4;
    localparam int CNT_W = 16;

    logic             aclk = 1'b0;
    logic             areset;
    logic [CNT_W-1:0] pkt_count;

    axis_upsizer_if #(.BYTES(1))     s_if ();
    axis_upsizer_if #(.BYTES(RATIO)) m_if ();

    axis_upsizer #(.RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    int cyc_now = 0;
    always @(posedge aclk) cyc_now <= cyc_now + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]          tx_data[$];
    bit                  tx_last[$];
    logic [8*RATIO-1:0]  rx_data[$];
    logic [RATIO-1:0]    rx_keep[$];
    bit                  rx_last[$];
    int                  rx_cyc[$];
    int                  last_s_cyc;

    task automatic clear_queues();
        tx_data.delete(); tx_last.delete();
        rx_data.delete(); rx_keep.delete(); rx_last.delete(); rx_cyc.delete();
    endtask

    // Pushes tx bytes through the DUT with random valid/ready percentages and
    // records every word accepted on the output side.
    task automatic run_stream(input int max_cycles, input int vpct, input int rpct,
                              output bit timed_out);
        int idx;
        int cyc;
        bit busy;
        idx = 0;
        cyc = 0;
        while (idx < tx_data.size() && cyc < max_cycles) begin
            @(negedge aclk);
            s_if.tvalid = ($urandom_range(99) < vpct);
            s_if.tdata  = tx_data[idx];
            s_if.tlast  = tx_last[idx];
            m_if.tready = ($urandom_range(99) < rpct);
            #1;
            if (m_if.tvalid && m_if.tready) begin
                rx_data.push_back(m_if.tdata); rx_keep.push_back(m_if.tkeep);
                rx_last.push_back(m_if.tlast); rx_cyc.push_back(cyc_now);
            end
            if (s_if.tvalid && s_if.tready) begin
                idx++;
                last_s_cyc = cyc_now;
            end
            cyc++;
        end
        busy = 1'b1;
        while (busy && cyc < max_cycles) begin
            @(negedge aclk);
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            m_if.tready = ($urandom_range(99) < rpct);
            #1;
            busy = m_if.tvalid;
            if (m_if.tvalid && m_if.tready) begin
                rx_data.push_back(m_if.tdata); rx_keep.push_back(m_if.tkeep);
                rx_last.push_back(m_if.tlast); rx_cyc.push_back(cyc_now);
            end
            cyc++;
        end
        @(negedge aclk);
        m_if.tready = 1'b1;
        #1;
        timed_out = (idx < tx_data.size()) || busy;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        areset = 1'b1;
        s_if.tvalid = 1'b1; s_if.tdata = 8'h55; s_if.tlast = 1'b1; m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_if.tready !== 1'b0) begin
                failures++;
                $display("FAIL reset_s_tready cycle %0d: got %b want 0", i, s_if.tready);
            end
            @(negedge aclk);
        end
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, pkt_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h cnt=%0d want all 0",
                     m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, pkt_count);
        end
        areset = 1'b0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_s_tready: got %b want 1", s_if.tready);
        end
    endtask

    task automatic test_full_word();
        bit to;
        clear_queues();
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 100, to);
        checks++;
        if (to || rx_data.size() != 1) begin
            failures++;
            $display("FAIL full_word_count: got %0d words (timeout=%b) want 1", rx_data.size(), to);
        end else begin
            checks++;
            if ({rx_last[0], rx_keep[0], rx_data[0]} !== {1'b1, 4'hF, 32'h44332211}) begin
                failures++;
                $display("FAIL full_word: got d=%h k=%h l=%b want d=44332211 k=f l=1",
                         rx_data[0], rx_keep[0], rx_last[0]);
            end
            checks++;
            if (rx_cyc[0] - last_s_cyc !== 1) begin
                failures++;
                $display("FAIL full_word_latency: got %0d want 1", rx_cyc[0] - last_s_cyc);
            end
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL full_word_pkt_count: got %0d want 1", pkt_count);
        end
    endtask

    task automatic test_partial_word();
        bit to;
        logic [31:0] ed[2];
        logic [3:0]  ek[2];
        bit          el[2];
        ed = '{32'hA4A3A2A1, 32'h0000A6A5};
        ek = '{4'hF, 4'h3};
        el = '{1'b0, 1'b1};
        clear_queues();
        tx_data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        tx_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 100, to);
        checks++;
        if (to || rx_data.size() != 2) begin
            failures++;
            $display("FAIL partial_count: got %0d words (timeout=%b) want 2", rx_data.size(), to);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({rx_last[i], rx_keep[i], rx_data[i]} !== {el[i], ek[i], ed[i]}) begin
                    failures++;
                    $display("FAIL partial_word%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                             i, rx_data[i], rx_keep[i], rx_last[i], ed[i], ek[i], el[i]);
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL partial_pkt_count: got %0d want 2", pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_queues();
        tx_data = '{8'h7A, 8'h7B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tx_last = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 100, to);
        checks++;
        if (to || rx_data.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d words (timeout=%b) want 4", rx_data.size(), to);
        end else begin
            checks++;
            if ({rx_last[0], rx_keep[0], rx_data[0], rx_last[1], rx_keep[1], rx_data[1]}
                !== {1'b1, 4'h1, 32'h0000007A, 1'b1, 4'h1, 32'h0000007B}) begin
                failures++;
                $display("FAIL b2b_single_bytes: got %h/%h/%b %h/%h/%b want 0000007a/1/1 0000007b/1/1",
                         rx_data[0], rx_keep[0], rx_last[0], rx_data[1], rx_keep[1], rx_last[1]);
            end
            checks++;
            if (rx_cyc[1] - rx_cyc[0] !== 1) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d want 1", rx_cyc[1] - rx_cyc[0]);
            end
            checks++;
            if ({rx_last[2], rx_keep[2], rx_data[2], rx_last[3], rx_keep[3], rx_data[3]}
                !== {1'b0, 4'hF, 32'h04030201, 1'b1, 4'hF, 32'h08070605}) begin
                failures++;
                $display("FAIL stream_words: got %h/%h/%b %h/%h/%b want 04030201/f/0 08070605/f/1",
                         rx_data[2], rx_keep[2], rx_last[2], rx_data[3], rx_keep[3], rx_last[3]);
            end
            checks++;
            if (rx_cyc[3] - rx_cyc[2] !== RATIO) begin
                failures++;
                $display("FAIL stream_spacing: got %0d want %0d", rx_cyc[3] - rx_cyc[2], RATIO);
            end
        end
        checks++;
        if (pkt_count !== 16'd5) begin
            failures++;
            $display("FAIL b2b_pkt_count: got %0d want 5", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1; s_if.tdata = 8'((i + 1) * 16); s_if.tlast = 1'b0;
            m_if.tready = 1'b0;
        end
        @(negedge aclk);
        s_if.tvalid = 1'b1; s_if.tdata = 8'h50; s_if.tlast = 1'b0; m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}
                !== {1'b0, 1'b1, 1'b0, 4'hF, 32'h40302010}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: got rdy=%b v=%b l=%b k=%h d=%h want rdy=0 v=1 l=0 k=f d=40302010",
                         i, s_if.tready, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata);
            end
            @(negedge aclk);
        end
        tx_data = '{8'h50, 8'h60, 8'h70, 8'h80};
        tx_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 100, to);
        checks++;
        if (to || rx_data.size() != 2) begin
            failures++;
            $display("FAIL bp_count: got %0d words (timeout=%b) want 2", rx_data.size(), to);
        end else begin
            checks++;
            if ({rx_last[0], rx_keep[0], rx_data[0], rx_last[1], rx_keep[1], rx_data[1]}
                !== {1'b0, 4'hF, 32'h40302010, 1'b1, 4'hF, 32'h80706050}) begin
                failures++;
                $display("FAIL bp_release: got %h/%h/%b %h/%h/%b want 40302010/f/0 80706050/f/1",
                         rx_data[0], rx_keep[0], rx_last[0], rx_data[1], rx_keep[1], rx_last[1]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        clear_queues();
        @(negedge aclk);
        s_if.tvalid = 1'b1; s_if.tdata = 8'hEE; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        @(negedge aclk);
        s_if.tdata = 8'hEF;
        @(negedge aclk);
        s_if.tvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid, pkt_count} !== '0) begin
            failures++;
            $display("FAIL midrst_cleared: got v=%b cnt=%0d want v=0 cnt=0", m_if.tvalid, pkt_count);
        end
        tx_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        tx_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 100, to);
        checks++;
        if (to || rx_data.size() != 1) begin
            failures++;
            $display("FAIL midrst_count: got %0d words (timeout=%b) want 1", rx_data.size(), to);
        end else begin
            checks++;
            if ({rx_last[0], rx_keep[0], rx_data[0]} !== {1'b1, 4'hF, 32'h04030201}) begin
                failures++;
                $display("FAIL midrst_word: got d=%h k=%h l=%b want d=04030201 k=f l=1",
                         rx_data[0], rx_keep[0], rx_last[0]);
            end
        end
    endtask

    task automatic test_mixed();
        bit                 to;
        int                 len;
        int                 lane;
        logic [7:0]         byt;
        logic [8*RATIO-1:0] w;
        logic [RATIO-1:0]   k;
        logic [8*RATIO-1:0] ed[$];
        logic [RATIO-1:0]   ek[$];
        bit                 el[$];
        clear_queues();
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        for (int p = 0; p < 1000; p++) begin
            len  = $urandom_range(20, 1);
            w    = '0;
            k    = '0;
            lane = 0;
            for (int b = 0; b < len; b++) begin
                byt = 8'($urandom);
                tx_data.push_back(byt);
                tx_last.push_back(b == len - 1);
                w[8*lane +: 8] = byt;
                k[lane] = 1'b1;
                lane++;
                if (lane == RATIO || b == len - 1) begin
                    ed.push_back(w); ek.push_back(k); el.push_back(b == len - 1);
                    w = '0; k = '0; lane = 0;
                end
            end
        end
        run_stream(60000, 80, 70, to);
        checks++;
        if (to || rx_data.size() != ed.size()) begin
            failures++;
            $display("FAIL mixed_count: got %0d words (timeout=%b) want %0d", rx_data.size(), to, ed.size());
        end
        for (int i = 0; i < rx_data.size() && i < ed.size(); i++) begin
            checks++;
            if ({rx_last[i], rx_keep[i], rx_data[i]} !== {el[i], ek[i], ed[i]}) begin
                failures++;
                $display("FAIL mixed_word%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                         i, rx_data[i], rx_keep[i], rx_last[i], ed[i], ek[i], el[i]);
            end
        end
        checks++;
        if (pkt_count !== 16'(1000)) begin
            failures++;
            $display("FAIL mixed_pkt_count: got %0d want 1000", pkt_count);
        end
    endtask

    initial begin
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = 1'b1;
        m_if.tready = 1'b1;
        last_s_cyc  = 0;
        test_reset();
        test_full_word();
        test_partial_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        test_mixed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

AXI-Stream width up-converter that consumes the 8-bit packet stream produced by the 4096-entry AXIS FIFO and packs it into wider words for the downstream datapath. Bytes are accumulated little-endian into an output register of RATIO bytes. A word is emitted when it fills or when tlast arrives, and tkeep marks valid byte lanes on the final partial word. It also maintains a free-running count of emitted packets for status readout.

## Interface
- RATIO, 4, input bytes per output word; legal values 2..8.
- CNT_W, 16, width of the packet counter.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tlast  in  1  input byte is last of packet.
- s_axis_tdata  in  8  input byte.
- s_axis_tready  out  1  upsizer can accept a byte this cycle.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tlast  out  1  output word ends a packet.
- m_axis_tdata  out  8*RATIO  output word; byte i in bits [8i+7:8i].
- m_axis_tkeep  out  RATIO  byte-lane valid mask.
- m_axis_tready  in  1  downstream accepts word.
- pkt_count  out  CNT_W  number of tlast words accepted downstream; wraps at 2^CNT_W.

## Operation
- Input handshake: s_fire = s_axis_tvalid && s_axis_tready. Output handshake: m_fire = m_axis_tvalid && m_axis_tready.
- Internal state:
  - byte_cnt, range 0..RATIO-1.
  - Accumulator acc_data and acc_keep.
  - Output register: data/keep/last/valid.
  - pkt_count.
- Byte placement: on s_fire, the byte is written to lane byte_cnt of acc_data, and acc_keep[byte_cnt] is set.
- Completing byte: s_fire && (byte_cnt == RATIO-1 || s_axis_tlast). On a completing byte, in the same edge:
  - The output register loads the accumulator contents merged with the current byte.
  - m_axis_tlast is set to s_axis_tlast.
  - m_axis_tvalid is set to 1.
  - The accumulator is cleared (acc_data = 0, acc_keep = 0) and byte_cnt is set to 0.
- Non-completing s_fire: byte_cnt increments.
- Unused lanes of a partial word: tdata bytes are 0 and tkeep bits are 0. tkeep is always a contiguous run of low ones, e.g. 4'b0111.
- A single-byte packet (tlast on lane 0) yields tkeep = 0...01.
- s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready).
  - Input stalls only while a word is held and not being taken.
  - Stalling the whole path on backpressure is intentional; no skid buffer.
- Output register:
  - A completing byte takes precedence and loads a new word (valid stays 1).
  - Otherwise, m_fire clears m_axis_tvalid.
  - Otherwise, the register holds.
- Output stability: while m_axis_tvalid && !m_axis_tready, tdata/tkeep/tlast/tvalid do not change.
- pkt_count increments on m_fire && m_axis_tlast, and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: all state is cleared on a rising edge with areset = 1.
  - Values: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tkeep 0, pkt_count 0, byte_cnt 0, accumulator 0.
  - s_axis_tready is 0 while areset is high, and 1 on the first cycle after.
- Reset mid-packet: the partial accumulator and any held output word are discarded, with no flush.
- Latency: the word is valid on m_axis the cycle after its completing byte is accepted.
- Throughput: one byte per cycle sustained when m_axis_tready = 1. A full word appears every RATIO cycles.
- Simultaneous m_fire and completing byte in one cycle: the old word leaves and the new word loads; no bubble.
- Back-to-back tlast bytes: two one-byte words on consecutive cycles.
- s_axis_tvalid low mid-word: the accumulator holds indefinitely.

## Structure
- Shared package: axis_upsizer_pkg.
  - BYTE_W = 8.
  - Function keep_mask(n) returning the low-n-ones RATIO mask.
  - Localparam bounds check for RATIO.
- Single module, no sub-modules. The accumulator and output register are two always blocks, plus one for pkt_count.

## Test plan
- Reset check: assert areset for 3 cycles with stimulus driven -> m_axis_tvalid = 0, s_axis_tready = 0 during reset, pkt_count = 0; s_axis_tready = 1 on the first cycle after.
- Full word (RATIO=4, ready = 1): bytes 0x11,0x22,0x33,0x44 with tlast on the 4th -> one word 0x44332211, tkeep = 4'hF, tlast = 1 the cycle after the 4th byte; pkt_count = 1.
- Partial word: packet 0xA1..0xA6, tlast on 0xA6 -> words 0xA4A3A2A1 (keep F, last 0) then 0x0000A6A5 (keep 3, last 1).
- Backpressure: m_axis_tready = 0 for 5 cycles while a word is held -> s_axis_tready = 0, output stable; on release, streaming resumes with no byte lost or duplicated.
- Mixed lengths: 1000 random packets of length 1..20 with random valid/ready -> scoreboard the byte stream and tkeep against a model; pkt_count = 1000 mod 2^16.
- Reset mid-packet: reset after 2 bytes of a packet -> no output word; the next packet 0x01..0x04 emits exactly 0x04030201.
